// File: rtl/video_source_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_source_ctrl_pkg
//  Description : Shared types and constants for the 576i video source
//                selector. Holds the source-select FSM state type, the
//                black pixel value and the frame geometry from which the
//                default loss timeout is derived.
//  Macros      : SRC_SWITCH_BLANK_EN adds the BLANK_EXT / BLANK_TC states.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_source_ctrl_pkg;

  // 576i frame geometry in pixel enables
  localparam int c_frameDots  = 864;
  localparam int c_frameLines = 625;

  // Two full frames without an external frame start counts as loss
  localparam int c_lossTimeoutDefault = 2 * c_frameDots * c_frameLines;

  localparam logic [5:0] c_black = 6'b000000;

  typedef enum logic [2:0] {
    ST_TC     = 3'd0,  // test card on output
    ST_TO_EXT = 3'd1,  // test card, waiting for frame boundary to go external
    ST_EXT    = 3'd2,  // external video on output
    ST_TO_TC  = 3'd3   // black, waiting for frame boundary to go to test card
`ifdef SRC_SWITCH_BLANK_EN
    ,
    ST_BLANK_EXT = 3'd4,  // one black frame before external video
    ST_BLANK_TC  = 3'd5   // one black frame before the test card
`endif
  } srcState_t;

endpackage
`default_nettype wire

// File: rtl/video_source_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_source_ctrl_if
//  Description : Bundles the raster timing, external strobe, both pixel
//                sources and the selected output of the video source
//                selector.
//  Ports       : pixelClockX1_en, frameLine[9:0], fieldLineDot[9:0],
//                extFrameStart, forceTestcard, tc{Red,Green,Blue}[5:0],
//                ext{Red,Green,Blue}[5:0]            -> into the selector
//                {red,green,blue}Out[5:0], extSelected, extLocked
//                                                    <- from the selector
//  Modports    : master (drives sources/timing), slave (the selector)
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_source_ctrl_if;

  logic       pixelClockX1_en;
  logic [9:0] frameLine;
  logic [9:0] fieldLineDot;
  logic       extFrameStart;
  logic       forceTestcard;
  logic [5:0] tcRed;
  logic [5:0] tcGreen;
  logic [5:0] tcBlue;
  logic [5:0] extRed;
  logic [5:0] extGreen;
  logic [5:0] extBlue;
  logic [5:0] redOut;
  logic [5:0] greenOut;
  logic [5:0] blueOut;
  logic       extSelected;
  logic       extLocked;

  modport master (
    output pixelClockX1_en, frameLine, fieldLineDot, extFrameStart,
           forceTestcard, tcRed, tcGreen, tcBlue, extRed, extGreen, extBlue,
    input  redOut, greenOut, blueOut, extSelected, extLocked
  );

  modport slave (
    input  pixelClockX1_en, frameLine, fieldLineDot, extFrameStart,
           forceTestcard, tcRed, tcGreen, tcBlue, extRed, extGreen, extBlue,
    output redOut, greenOut, blueOut, extSelected, extLocked
  );

endinterface
`default_nettype wire

// File: rtl/video_source_ctrl_presence.sv
`default_nettype none
// ============================================================================
//  Module      : video_presence_monitor
//  Description : Watches the external frame-start strobe. A timeout counter
//                of pixel enables since the last strobe flags loss when it
//                saturates; a lock counter of strobes since the last loss
//                flags lock once it reaches LOCK_FRAMES.
//  Ports       : pixelClockX6    in   system clock
//                nReset          in   asynchronous active-low reset
//                pixelClockX1_en in   pixel enable
//                extFrameStart   in   external frame-start strobe
//                loss            out  no strobe for LOSS_TIMEOUT enables
//                extLocked       out  LOCK_FRAMES strobes seen, no loss
//  Revision    : 1.0 - initial release
// ============================================================================
module video_presence_monitor
  import video_source_ctrl_pkg::*;
#(
  parameter int LOSS_TIMEOUT = c_lossTimeoutDefault,
  parameter int LOCK_FRAMES  = 4
) (
  input  wire logic pixelClockX6,
  input  wire logic nReset,
  input  wire logic pixelClockX1_en,
  input  wire logic extFrameStart,
  output logic      loss,
  output logic      extLocked
);

  localparam logic [20:0] c_lossLimit = 21'(LOSS_TIMEOUT);
  localparam logic [2:0]  c_lockLimit = 3'(LOCK_FRAMES);

  logic [20:0] r_timeoutCnt;
  logic [2:0]  r_lockCnt;

  // A strobe always clears the counter, so a strobe landing on the enable
  // that would saturate it prevents the loss.
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      r_timeoutCnt <= 21'd0;
    end else if (extFrameStart) begin
      r_timeoutCnt <= 21'd0;
    end else if (pixelClockX1_en && (r_timeoutCnt != c_lossLimit)) begin
      r_timeoutCnt <= r_timeoutCnt + 21'd1;
    end
  end

  // A strobe that ends a loss is the first of a fresh lock sequence.
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      r_lockCnt <= 3'd0;
    end else if (extFrameStart) begin
      if (loss) begin
        r_lockCnt <= 3'd1;
      end else if (r_lockCnt != c_lockLimit) begin
        r_lockCnt <= r_lockCnt + 3'd1;
      end
    end else if (loss) begin
      r_lockCnt <= 3'd0;
    end
  end

  assign loss      = (r_timeoutCnt == c_lossLimit);
  assign extLocked = (r_lockCnt == c_lockLimit) && !loss;

endmodule
`default_nettype wire

// File: rtl/video_source_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : video_source_ctrl
//  Description : Selects the test card or external video for the 576i RGB
//                output. Switches only at the local frame boundary
//                (frameLine 0, fieldLineDot 0) and mutes to black while a
//                switch towards the test card is pending.
//  Ports       : pixelClockX6 in  system clock
//                nReset       in  asynchronous active-low reset
//                vid          slave modport of video_source_ctrl_if
//                             (timing, strobe, force, both sources in;
//                              registered RGB, extSelected, extLocked out)
//  Macros      : SRC_SWITCH_BLANK_EN inserts one full black frame on each
//                source switch.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_source_ctrl
  import video_source_ctrl_pkg::*;
#(
  parameter int LOSS_TIMEOUT = c_lossTimeoutDefault,
  parameter int LOCK_FRAMES  = 4
) (
  input wire logic          pixelClockX6,
  input wire logic          nReset,
  video_source_ctrl_if.slave vid
);

  srcState_t  r_state;
  srcState_t  w_nextState;
  logic       w_loss;
  logic       w_extLocked;
  logic       w_fb;
  logic       w_extSel;
  logic [5:0] w_red;
  logic [5:0] w_green;
  logic [5:0] w_blue;
  logic [5:0] r_red;
  logic [5:0] r_green;
  logic [5:0] r_blue;

  assign w_fb = vid.pixelClockX1_en && (vid.frameLine == 10'd0) &&
                (vid.fieldLineDot == 10'd0);

  video_presence_monitor #(
    .LOSS_TIMEOUT (LOSS_TIMEOUT),
    .LOCK_FRAMES  (LOCK_FRAMES)
  ) u_presence (
    .pixelClockX6    (pixelClockX6),
    .nReset          (nReset),
    .pixelClockX1_en (vid.pixelClockX1_en),
    .extFrameStart   (vid.extFrameStart),
    .loss            (w_loss),
    .extLocked       (w_extLocked)
  );

  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_TC;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_red       = c_black;
    w_green     = c_black;
    w_blue      = c_black;
    w_extSel    = 1'b0;
    case (r_state)
      ST_TC: begin
        w_red   = vid.tcRed;
        w_green = vid.tcGreen;
        w_blue  = vid.tcBlue;
        if (w_extLocked && !vid.forceTestcard) begin
          w_nextState = ST_TO_EXT;
        end
      end
      ST_TO_EXT: begin
        w_red   = vid.tcRed;
        w_green = vid.tcGreen;
        w_blue  = vid.tcBlue;
        // Abort has priority, so a loss coinciding with fb stays on test card
        if (!w_extLocked || vid.forceTestcard) begin
          w_nextState = ST_TC;
        end else if (w_fb) begin
`ifdef SRC_SWITCH_BLANK_EN
          w_nextState = ST_BLANK_EXT;
`else
          w_nextState = ST_EXT;
`endif
        end
      end
      ST_EXT: begin
        w_red    = vid.extRed;
        w_green  = vid.extGreen;
        w_blue   = vid.extBlue;
        w_extSel = 1'b1;
        if (w_loss || vid.forceTestcard) begin
          w_nextState = ST_TO_TC;
        end
      end
      ST_TO_TC: begin
        if (w_fb) begin
`ifdef SRC_SWITCH_BLANK_EN
          w_nextState = ST_BLANK_TC;
`else
          w_nextState = ST_TC;
`endif
        end
      end
`ifdef SRC_SWITCH_BLANK_EN
      ST_BLANK_EXT: begin
        w_extSel = 1'b1;
        if (w_loss || vid.forceTestcard) begin
          w_nextState = ST_BLANK_TC;
        end else if (w_fb) begin
          w_nextState = ST_EXT;
        end
      end
      ST_BLANK_TC: begin
        if (w_fb) begin
          w_nextState = ST_TC;
        end
      end
`endif
      default: begin
        w_nextState = ST_TC;
      end
    endcase
  end

  // Pixels advance only on the pixel enable and hold in between
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      r_red   <= c_black;
      r_green <= c_black;
      r_blue  <= c_black;
    end else if (vid.pixelClockX1_en) begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign vid.redOut      = r_red;
  assign vid.greenOut    = r_green;
  assign vid.blueOut     = r_blue;
  assign vid.extSelected = w_extSel;
  assign vid.extLocked   = w_extLocked;

endmodule
`default_nettype wire

// File: tb/tb_video_source_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_source_ctrl
//  Description : Self-checking bench for video_source_ctrl on a reduced
//                raster (16 dots x 8 lines). A stimulus thread drives one
//                pixel enable every six clocks, updates a frame-level
//                reference model and queues expected pixels and status; a
//                monitor thread pops and compares after each enable.
//  Macros      : SRC_SWITCH_BLANK_EN enables the blank-frame model and the
//                blank-frame length check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_source_ctrl;

  localparam int DOTS  = 16;
  localparam int LINES = 8;
  localparam int FRAME = DOTS * LINES;
  localparam int LOSS  = 2 * FRAME;
  localparam int LOCK  = 4;

  // Reference model source modes
  localparam int M_TC       = 0;
  localparam int M_PEND_EXT = 1;
  localparam int M_EXT      = 2;
  localparam int M_PEND_TC  = 3;
  localparam int M_BLANK_EXT = 4;
  localparam int M_BLANK_TC  = 5;

  logic pixelClockX6 = 1'b0;
  logic nReset       = 1'b0;

  always #5 pixelClockX6 = ~pixelClockX6;

  video_source_ctrl_if vif ();

  video_source_ctrl #(
    .LOSS_TIMEOUT (LOSS),
    .LOCK_FRAMES  (LOCK)
  ) dut (
    .pixelClockX6 (pixelClockX6),
    .nReset       (nReset),
    .vid          (vif)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [17:0] rgbQ[$];
  logic [1:0]  statQ[$];

  // Local raster position and stimulus level
  int dotPos     = 0;
  int linePos    = 0;
  bit forceLevel = 1'b0;

  // Reference model: enables since last strobe, strobes since last loss
  int mode        = M_TC;
  int sinceStrobe = 0;
  int lockCount   = 0;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] randPix();
    logic [17:0] p;
    p = 18'($urandom);
`ifdef SRC_SWITCH_BLANK_EN
    p = p | 18'b000001_000001_000001;
`endif
    return p;
  endfunction

  function automatic int nextMode(input int m, input bit locked, input bit lost,
                                  input bit frc, input bit fb);
    int n;
    n = m;
    case (m)
      M_TC:       if (locked && !frc) n = M_PEND_EXT;
      M_PEND_EXT: begin
        if (!locked || frc) n = M_TC;
`ifdef SRC_SWITCH_BLANK_EN
        else if (fb) n = M_BLANK_EXT;
`else
        else if (fb) n = M_EXT;
`endif
      end
      M_EXT:      if (lost || frc) n = M_PEND_TC;
`ifdef SRC_SWITCH_BLANK_EN
      M_PEND_TC:  if (fb) n = M_BLANK_TC;
      M_BLANK_EXT: begin
        if (lost || frc) n = M_BLANK_TC;
        else if (fb) n = M_EXT;
      end
      M_BLANK_TC: if (fb) n = M_TC;
`else
      M_PEND_TC:  if (fb) n = M_TC;
`endif
      default:    n = M_TC;
    endcase
    return n;
  endfunction

  function automatic bit modelLost();
    return sinceStrobe == LOSS;
  endfunction

  function automatic bit modelLocked();
    return (lockCount == LOCK) && !modelLost();
  endfunction

  // One pixel enable followed by five idle clocks
  task automatic enableStep(input bit strobe);
    logic [17:0] tcPix;
    logic [17:0] extPix;
    logic [17:0] expPix;
    bit fb;
    bit lostNow;
    bit lockedNow;
    bit sel;
    @(negedge pixelClockX6);
    tcPix  = randPix();
    extPix = randPix();
    vif.pixelClockX1_en = 1'b1;
    vif.extFrameStart   = strobe;
    vif.forceTestcard   = forceLevel;
    vif.frameLine       = 10'(linePos);
    vif.fieldLineDot    = 10'(dotPos);
    {vif.tcRed, vif.tcGreen, vif.tcBlue}    = tcPix;
    {vif.extRed, vif.extGreen, vif.extBlue} = extPix;
    fb = (linePos == 0) && (dotPos == 0);
    if (dotPos == DOTS - 1) begin
      dotPos  = 0;
      linePos = (linePos == LINES - 1) ? 0 : linePos + 1;
    end else begin
      dotPos++;
    end

    // Pixel shown is decided by the mode in force before this enable
    lostNow   = modelLost();
    lockedNow = modelLocked();
    case (mode)
      M_TC, M_PEND_EXT: expPix = tcPix;
      M_EXT:            expPix = extPix;
      default:          expPix = 18'd0;
    endcase
    rgbQ.push_back(expPix);
    mode = nextMode(mode, lockedNow, lostNow, forceLevel, fb);

    if (strobe) begin
      lockCount   = lostNow ? 1 : ((lockCount < LOCK) ? lockCount + 1 : LOCK);
      sinceStrobe = 0;
    end else if (sinceStrobe < LOSS) begin
      sinceStrobe++;
    end
    if (modelLost()) lockCount = 0;
    lockedNow = modelLocked();
    lostNow   = modelLost();
    repeat (2) mode = nextMode(mode, lockedNow, lostNow, forceLevel, 1'b0);
    sel = (mode == M_EXT) || (mode == M_BLANK_EXT);
    statQ.push_back({sel, lockedNow});

    repeat (5) begin
      @(negedge pixelClockX6);
      vif.pixelClockX1_en = 1'b0;
      vif.extFrameStart   = 1'b0;
    end
  endtask

  task automatic runStrobes(input int count, input int spacing);
    for (int s = 0; s < count; s++) begin
      enableStep(1'b1);
      repeat (spacing - 1) enableStep(1'b0);
    end
  endtask

  task automatic doReset();
    nReset = 1'b0;
    repeat (2) @(negedge pixelClockX6);
    check("resetRgb", {vif.redOut, vif.greenOut, vif.blueOut}, 18'd0);
    check("resetStatus", {16'd0, vif.extSelected, vif.extLocked}, 18'd0);
    mode        = M_TC;
    sinceStrobe = 0;
    lockCount   = 0;
    nReset      = 1'b1;
  endtask

  // Monitor: pixels right after each enable, settled status three clocks on
  initial begin
    logic [17:0] expRgb;
    logic [1:0]  expStat;
`ifdef SRC_SWITCH_BLANK_EN
    int blankRun = 0;
`endif
    forever begin
      @(posedge pixelClockX6);
      if (vif.pixelClockX1_en === 1'b1) begin
        #1;
        if (rgbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rgbQueue: got empty expected entry at %0t", $time);
        end else begin
          expRgb = rgbQ.pop_front();
          check("rgb", {vif.redOut, vif.greenOut, vif.blueOut}, expRgb);
        end
`ifdef SRC_SWITCH_BLANK_EN
        if (vif.extSelected && ({vif.redOut, vif.greenOut, vif.blueOut} == 18'd0)) begin
          blankRun++;
        end else begin
          if (vif.extSelected && blankRun > 0)
            check("blankFrameLen", 18'(blankRun), 18'(FRAME));
          blankRun = 0;
        end
`endif
        repeat (3) @(posedge pixelClockX6);
        #1;
        if (statQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL statQueue: got empty expected entry at %0t", $time);
        end else begin
          expStat = statQ.pop_front();
          check("selLocked", {16'd0, vif.extSelected, vif.extLocked}, {16'd0, expStat});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.pixelClockX1_en = 1'b0;
    vif.frameLine       = 10'd0;
    vif.fieldLineDot    = 10'd0;
    vif.extFrameStart   = 1'b0;
    vif.forceTestcard   = 1'b0;
    {vif.tcRed, vif.tcGreen, vif.tcBlue}    = 18'd0;
    {vif.extRed, vif.extGreen, vif.extBlue} = 18'd0;
    doReset();

    // No external input: test card forever, never locked
    repeat (LOSS + 40) enableStep(1'b0);
    repeat ($urandom_range(0, 50)) enableStep(1'b0);

    // Lock at half-frame spacing, switch at next frame boundary
    runStrobes(8, FRAME / 2);

    // Strobes stop: loss, black until boundary, then test card
    repeat (LOSS + FRAME + 10) enableStep(1'b0);

    // Relock, then force the test card mid-frame and hold it through relock
    runStrobes(6, FRAME / 2);
    repeat (21) enableStep(1'b0);
    forceLevel = 1'b1;
    runStrobes(6, FRAME / 2);
    forceLevel = 1'b0;
    runStrobes(4, FRAME / 2);

    // Strobe exactly where the timeout would saturate, then one enable late
    runStrobes(4, LOSS);
    runStrobes(3, LOSS + 1);

    // Randomized spacing and force
    repeat (8) begin
      forceLevel = ($urandom_range(0, 3) == 0);
      runStrobes($urandom_range(1, 3), $urandom_range(FRAME / 4, LOSS + 2));
    end
    forceLevel = 1'b0;

    // Mid-frame reset while external is shown, then relock from scratch
    runStrobes(6, FRAME / 2);
    repeat (37) enableStep(1'b0);
    doReset();
    runStrobes(6, FRAME / 2);

    repeat (8) @(negedge pixelClockX6);
    if (rgbQ.size() != 0 || statQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d/%0d left expected 0/0", rgbQ.size(), statQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_source_ctrl.md
# video_source_ctrl

Selects what drives the 576i RGB output path: the internal test card, or external video. It watches the external frame-start strobe for presence and stability, and switches source only at the local frame boundary (frameLine 0, fieldLineDot 0). During a loss it mutes to black. The block sits between the test card generator, the external video capture path and the RGB output stage, and it runs in the pixelClockX6 domain.

## Interface
Parameters:
- LOSS_TIMEOUT, 1080000, number of pixel enables without an external frame start before the input is declared lost (about 2 frames).
- LOCK_FRAMES, 4, number of consecutive in-time external frame starts needed to declare lock.

Ports (reset is asynchronous, active-low; one clock):
- pixelClockX6  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- pixelClockX1_en  in  1  pixel enable, one cycle in six
- frameLine  in  10  local frame line counter
- fieldLineDot  in  10  local dot counter
- extFrameStart  in  1  single-cycle external frame-start strobe, already synchronous to pixelClockX6
- forceTestcard  in  1  level; holds the test card as the output source
- tcRed / tcGreen / tcBlue  in  6 each  test card pixel
- extRed / extGreen / extBlue  in  6 each  external pixel
- redOut / greenOut / blueOut  out  6 each  selected pixel, registered
- extSelected  out  1  1 when the external source is being output
- extLocked  out  1  external input currently meets the lock criteria

## Operation
- Frame boundary (fb) = pixelClockX1_en && frameLine==0 && fieldLineDot==0.
- Timeout counter (21-bit, unsigned):
  - cleared on extFrameStart;
  - otherwise increments on each pixelClockX1_en;
  - saturates at LOSS_TIMEOUT.
- loss = (counter == LOSS_TIMEOUT).
- If extFrameStart occurs in the same cycle the counter would reach LOSS_TIMEOUT, extFrameStart wins: the counter clears and no loss is raised.
- Lock counter (3-bit):
  - increments on each extFrameStart, saturating at LOCK_FRAMES;
  - cleared when loss is raised.
- extLocked = (lockCnt == LOCK_FRAMES) && !loss.
- FSM states:
  - TC: outputs the test card. Goes to TO_EXT when extLocked && !forceTestcard.
  - TO_EXT: outputs the test card. Goes to EXT on fb. Returns to TC if extLocked drops or forceTestcard rises before fb.
  - EXT: outputs external video. On loss it goes to TO_TC. On forceTestcard it goes to TO_TC.
  - TO_TC: outputs black (6'b0 on all channels). Goes to TC on fb.
- Source mux and output registers update only on pixelClockX1_en. The outputs hold their values between enables.
- extSelected = 1 only in EXT (and in BLANK_EXT when the macro is enabled).

## Timing
- Reset: redOut/greenOut/blueOut = 0, extSelected = 0, extLocked = 0, FSM = TC, both counters = 0.
- Output latency: 1 pixel enable. The input sampled at enable N appears at the outputs after enable N.
- State transitions take effect on the clock edge where their condition holds. The output of the new state is visible from the next enable.
- If reset asserts mid-frame, the block returns to TC immediately. After release it needs LOCK_FRAMES fresh frame starts before reaching EXT.
- An fb coinciding with a loss while in TO_EXT: the block goes to TC, not EXT.

## Configuration
- SRC_SWITCH_BLANK_EN defined:
  - extra states BLANK_EXT and BLANK_TC are inserted;
  - fb in TO_EXT goes to BLANK_EXT; fb in TO_TC goes to BLANK_TC;
  - both blank states output black for one full frame and leave on the next fb, to EXT and TC respectively;
  - a loss or forceTestcard in BLANK_EXT goes to BLANK_TC.
- SRC_SWITCH_BLANK_EN undefined: the blank states do not exist, and switches are immediate at fb as described in Operation.

## Structure
- Shared package holds:
  - FSM state enum;
  - the 6-bit black constant;
  - the 864 dots × 625 lines frame geometry constants, from which the LOSS_TIMEOUT default is derived.
- One natural sub-module: video_presence_monitor, containing the timeout counter, lock counter, loss and extLocked logic.
- The FSM and the registered output mux stay in the top module.

## Test plan
- Reset, no extFrameStart -> black outputs during reset, then the test card after reset; extSelected=0; extLocked stays 0 indefinitely.
- 4 extFrameStart pulses at 540000-enable spacing -> extLocked=1 after the 4th pulse; extSelected=1 starting at the next fb and not before; the outputs match extRed/extGreen/extBlue with 1-enable latency.
- In EXT, stop the strobes -> loss raised 1080000 enables after the last pulse; black is output until the next fb, then the test card; extLocked=0.
- In EXT, assert forceTestcard mid-frame -> black until fb, then the test card; while forceTestcard is held, relock does not switch back to EXT.
- extFrameStart arriving exactly on the enable where the counter hits 1080000 -> no loss; extLocked is unchanged.
- With SRC_SWITCH_BLANK_EN: lock -> one full black frame between the test card and external video, with extSelected=1 during that frame; the bench checks the frame is 540000 enables long.
